// File: rtl/dec_deser_pkg.sv
// Shared definitions for the decimator receive-side deserializer.
package dec_deser_pkg;

  localparam int DATA_W_DEFAULT = 22;
  localparam int ERR_CNT_W      = 8;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    SHIFT    = 2'd2,
    DISCARD  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/dec_sync_fifo.sv
// Single-clock FIFO for deserialized samples. Pointers carry one extra MSB
// so full and empty can be told apart; a push into a full FIFO is accepted
// only when a pop happens on the same edge.
module dec_sync_fifo #(
  parameter int DATA_W     = 22,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_W-1:0]             wdata,
  input  logic                          pop,
  output logic [DATA_W-1:0]             rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign level   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer advance and storage write; storage cleared so the head reads 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/dec_deserializer_22b.sv
// Receive-side deserializer: rebuilds MSB-first serial frames into samples,
// rejects frames of the wrong length and buffers good samples in a FIFO.
// Optional saturating error counter enabled by DEC_DESER_ERR_CNT_EN.
//
// state    | meaning
// WAIT_LOW | after reset; ignore any frame whose start was missed
// IDLE     | between frames, waiting for frame_sync_i high
// SHIFT    | collecting bits of a frame
// DISCARD  | frame overran; wait for frame_sync_i low
module dec_deserializer_22b
  import dec_deser_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ser_i,
  input  logic                          frame_sync_i,
  output logic [DATA_W-1:0]             word_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          frame_err_o,
  output logic                          overflow_o
`ifdef DEC_DESER_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]          err_cnt_o
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  rx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              last_bit;
  logic              commit;
  logic              too_long;
  logic              too_short;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;

  assign last_bit  = (bit_cnt == CNT_W'(DATA_W));
  assign commit    = (state == SHIFT) && !frame_sync_i && last_bit;
  assign too_long  = (state == SHIFT) && frame_sync_i && last_bit;
  assign too_short = (state == SHIFT) && !frame_sync_i && !last_bit;
  assign valid_o   = !fifo_empty;
  assign pop       = valid_o && ready_i;
  assign drop      = commit && fifo_full && !pop;

  // Receiver FSM, shift register, bit counter and registered error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_LOW;
      shreg       <= '0;
      bit_cnt     <= '0;
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      frame_err_o <= too_long || too_short;
      overflow_o  <= drop;
      case (state)
        WAIT_LOW: if (!frame_sync_i) state <= IDLE;
        IDLE: begin
          if (frame_sync_i) begin
            shreg   <= {shreg[DATA_W-2:0], ser_i};
            bit_cnt <= CNT_W'(1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (frame_sync_i) begin
            if (last_bit) begin
              state <= DISCARD;
            end else begin
              shreg   <= {shreg[DATA_W-2:0], ser_i};
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else begin
            state <= IDLE;
          end
        end
        DISCARD: if (!frame_sync_i) state <= IDLE;
        default: state <= WAIT_LOW;
      endcase
    end
  end

  dec_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (commit),
    .wdata (shreg),
    .pop   (pop),
    .rdata (word_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

`ifdef DEC_DESER_ERR_CNT_EN
  // Saturating count of frame errors and overflows, updated with the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_o <= '0;
    end else if ((too_long || too_short || drop) && (err_cnt_o != '1)) begin
      err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dec_deserializer_22b.sv
// Bench for dec_deserializer_22b: frame-length model plus sample queue,
// checked on every falling edge, with directed frames.
module tb_dec_deserializer_22b;

  localparam int DW    = 22;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          ser_i;
  logic          frame_sync_i;
  logic [DW-1:0] word_o;
  logic          valid_o;
  logic          ready_i;
  logic [LW-1:0] level_o;
  logic          frame_err_o;
  logic          overflow_o;
`ifdef DEC_DESER_ERR_CNT_EN
  logic [7:0]    err_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  dec_deserializer_22b #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .ser_i        (ser_i),
    .frame_sync_i (frame_sync_i),
    .word_o       (word_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .level_o      (level_o),
    .frame_err_o  (frame_err_o),
    .overflow_o   (overflow_o)
`ifdef DEC_DESER_ERR_CNT_EN
    ,
    .err_cnt_o    (err_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is a run of high frame_sync samples; only runs that start
  // after a low sample following reset count. A run of exactly DW bits is a
  // sample, shorter ends in an error at its end, longer errors on bit DW+1.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] mword = '0;
  int            run_len = 0;
  bit            armed = 0;
  bit            e_err = 0;
  bit            e_ovf = 0;
  int            e_cnt = 0;
  bit            m_full, m_pop, m_commit;

  logic [DW-1:0] seen[$];
  int            err_seen = 0;
  int            ovf_seen = 0;
  int            valid_cycles = 0;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      run_len = 0;
      armed   = 0;
      e_err   = 0;
      e_ovf   = 0;
      e_cnt   = 0;
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_level", 32'(level_o), 0);
      chk("rst_word", 32'(word_o), 0);
      chk("rst_frame_err", 32'(frame_err_o), 0);
      chk("rst_overflow", 32'(overflow_o), 0);
`ifdef DEC_DESER_ERR_CNT_EN
      chk("rst_err_cnt", 32'(err_cnt_o), 0);
`endif
    end else begin
      chk("valid", 32'(valid_o), 32'(mq.size() > 0));
      chk("level", 32'(level_o), 32'(mq.size()));
      if (mq.size() > 0) chk("word", 32'(word_o), 32'(mq[0]));
      chk("frame_err", 32'(frame_err_o), 32'(e_err));
      chk("overflow", 32'(overflow_o), 32'(e_ovf));
`ifdef DEC_DESER_ERR_CNT_EN
      chk("err_cnt", 32'(err_cnt_o), 32'(e_cnt));
`endif
      if (valid_o && ready_i) seen.push_back(word_o);
      if (valid_o) valid_cycles++;
      if (frame_err_o) err_seen++;
      if (overflow_o) ovf_seen++;

      m_full   = (mq.size() == DEPTH);
      m_pop    = ready_i && (mq.size() > 0);
      m_commit = 0;
      e_err    = 0;
      e_ovf    = 0;
      if (!armed) begin
        if (!frame_sync_i) armed = 1;
      end else if (frame_sync_i) begin
        run_len++;
        mword = {mword[DW-2:0], ser_i};
        if (run_len == DW + 1) e_err = 1;
      end else begin
        if (run_len == DW) m_commit = 1;
        else if (run_len > 0 && run_len < DW) e_err = 1;
        run_len = 0;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_commit) begin
        if (!m_full || m_pop) mq.push_back(mword);
        else e_ovf = 1;
      end
      if ((e_err || e_ovf) && e_cnt < 255) e_cnt++;
    end
  end

  function automatic logic [31:0] seen_at(int idx);
    return (seen.size() > idx) ? 32'(seen[idx]) : 32'hDEAD_BEEF;
  endfunction

  task automatic clr();
    seen.delete();
    err_seen     = 0;
    ovf_seen     = 0;
    valid_cycles = 0;
  endtask

  task automatic send_bits(input logic [DW-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      frame_sync_i = 1'b1;
      ser_i        = (i < DW) ? w[DW-1-i] : 1'b0;
    end
  endtask

  task automatic end_frame();
    @(posedge clk); #1;
    frame_sync_i = 1'b0;
    ser_i        = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] w, input int n);
    send_bits(w, n);
    end_frame();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && level_o != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_timeout", 32'(level_o), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ser_i = 1'b0; frame_sync_i = 1'b0; ready_i = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(2);
    chk("reset_state_level", 32'(level_o), 0);
    chk("reset_state_valid", 32'(valid_o), 0);

    // single good frame
    clr(); ready_i = 1'b1;
    send_frame(22'h2A5A5A, 22);
    idle(4);
    chk("s1_count", 32'(seen.size()), 1);
    chk("s1_word", seen_at(0), 32'h2A5A5A);
    chk("s1_valid_cycles", 32'(valid_cycles), 1);
    chk("s1_level", 32'(level_o), 0);

    // short frame
    clr();
    send_frame(22'h155555, 21);
    idle(4);
    chk("s2_err_pulses", 32'(err_seen), 1);
    chk("s2_no_word", 32'(valid_cycles), 0);
`ifdef DEC_DESER_ERR_CNT_EN
    chk("s2_err_cnt", 32'(err_cnt_o), 1);
`endif

    // long frame then a good one
    clr();
    send_frame(22'h3FFFFF, 23);
    idle(3);
    chk("s3_err_pulses", 32'(err_seen), 1);
    chk("s3_no_word", 32'(seen.size()), 0);
    send_frame(22'h3FFFFF, 22);
    idle(4);
    chk("s3_word", seen_at(0), 32'h3FFFFF);
`ifdef DEC_DESER_ERR_CNT_EN
    chk("s3_err_cnt", 32'(err_cnt_o), 2);
`endif

    // overflow with back-to-back frames
    clr(); ready_i = 1'b0;
    for (int k = 1; k <= 5; k++) send_frame(22'(k), 22);
    idle(3);
    chk("s4_level_full", 32'(level_o), 4);
    chk("s4_overflow_pulses", 32'(ovf_seen), 1);
    ready_i = 1'b1;
    drain();
    idle(1);
    chk("s4_count", 32'(seen.size()), 4);
    for (int k = 0; k < 4; k++) chk("s4_order", seen_at(k), 32'(k + 1));

    // full FIFO, commit coincident with a pop
    clr(); ready_i = 1'b0;
    for (int k = 10; k <= 13; k++) send_frame(22'(k), 22);
    send_bits(22'd14, 22);
    @(posedge clk); #1;
    frame_sync_i = 1'b0; ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    idle(3);
    chk("s5_level", 32'(level_o), 4);
    chk("s5_no_overflow", 32'(ovf_seen), 0);
    ready_i = 1'b1;
    drain();
    idle(1);
    chk("s5_count", 32'(seen.size()), 5);
    for (int k = 0; k < 5; k++) chk("s5_order", seen_at(k), 32'(k + 10));

    // reset mid-frame, released while frame_sync is still high
    clr();
    send_bits(22'h155555, 10);
    @(posedge clk); #1;
    rst = 1'b1; ser_i = 1'b1;
    idle(2);
    rst = 1'b0;
    send_bits(22'h3FFFFF, 10);
    end_frame();
    idle(3);
    chk("s6_no_err", 32'(err_seen), 0);
    chk("s6_no_word", 32'(seen.size()), 0);
    send_frame(22'h0ABCDE, 22);
    idle(4);
    chk("s6_word", seen_at(0), 32'h0ABCDE);
`ifdef DEC_DESER_ERR_CNT_EN
    chk("s6_err_cnt", 32'(err_cnt_o), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_deserializer_22b.md
# dec_deserializer_22b

Receive-side deserializer that sits directly downstream of the decimator's serial output. It takes the MSB-first serial word stream and its frame strobe and rebuilds 22-bit decimated samples. It checks each frame for exact length and buffers complete samples in a small FIFO. Samples are presented on a valid/ready interface to the consuming logic (register file, DMA or test readout).

## Interface
- DATA_W, 22, sample width; also the required frame length in bits.
- FIFO_DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- clk  in  1  single system clock; same clock as the serializer, so no input synchronizer is used.
- rst  in  1  reset, asynchronous, active-high.
- ser_i  in  1  serial data, MSB first, one bit per clk while frame_sync_i is high.
- frame_sync_i  in  1  high for exactly DATA_W consecutive cycles per sample.
- word_o  out  DATA_W  FIFO head sample (two's complement, passed through unchanged).
- valid_o  out  1  FIFO not empty.
- ready_i  in  1  consumer accepts word_o; a pop occurs when valid_o && ready_i.
- level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- frame_err_o  out  1  one-cycle pulse on a short or long frame.
- overflow_o  out  1  one-cycle pulse when a complete word is dropped because the FIFO is full.
- err_cnt_o  out  8  saturating error count; present only with DEC_DESER_ERR_CNT_EN.

## Operation
- Receiver FSM has four states: WAIT_LOW (the reset state), IDLE, SHIFT and DISCARD.
- WAIT_LOW: go to IDLE when frame_sync_i is sampled low. This ensures a frame whose start was not seen is ignored, and no error is flagged for it.
- IDLE:
  - frame_sync_i=1: shift ser_i into the shift register, set bit count to 1, go to SHIFT.
  - frame_sync_i=0: stay in IDLE.
- SHIFT, frame_sync_i=1 and count<DATA_W: shift left with ser_i entering the LSB, count+1.
- SHIFT, frame_sync_i=1 and count==DATA_W: the frame is too long. Pulse frame_err_o, discard the word, go to DISCARD.
- SHIFT, frame_sync_i=0 and count==DATA_W: commit the shift register to the FIFO, go to IDLE.
- SHIFT, frame_sync_i=0 and count<DATA_W: the frame is too short. Pulse frame_err_o, discard the word, go to IDLE.
- DISCARD: go to IDLE on frame_sync_i=0.
- FIFO push on commit:
  - Not full: write the word.
  - Full with a simultaneous pop: write the word; no overflow.
  - Full without a pop: drop the new word, pulse overflow_o; FIFO contents unchanged.
- FIFO pop: on valid_o && ready_i, advance the read pointer. Output order is strictly FIFO order.
- Pointers wrap modulo FIFO_DEPTH, with an extra MSB to distinguish full from empty.
- level_o = write pointer − read pointer.

## Timing
- Reset values: word_o=0, valid_o=0, level_o=0, frame_err_o=0, overflow_o=0, err_cnt_o=0. FSM resets to WAIT_LOW.
- Reset is asynchronous. Asserting rst mid-frame discards the partial word and empties the FIFO.
- Latency:
  - The edge that samples frame_sync_i low after bit DATA_W writes the FIFO.
  - valid_o is high in the following cycle, with word_o valid.
  - Total latency is 1 cycle from the last bit's frame_sync_i low sample.
- Minimum inter-frame gap is 1 low cycle; back-to-back frames separated by one low cycle are all accepted.
- frame_err_o and overflow_o are registered pulses, asserted the cycle after the detecting edge. The two can never coincide.
- word_o is stable while valid_o=1 && ready_i=0.

## Configuration
- DEC_DESER_ERR_CNT_EN defined:
  - Adds port err_cnt_o[7:0].
  - The count increments by 1 on each frame_err_o or overflow_o event and saturates at 255.
  - Cleared only by rst.
- DEC_DESER_ERR_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package dec_deser_pkg holds:
  - DATA_W default (22) and ERR_CNT_W (8).
  - The FSM state enum: WAIT_LOW, IDLE, SHIFT, DISCARD.
- One sub-module, dec_sync_fifo (parameterised DATA_W, FIFO_DEPTH; push/pop/full/empty/level).
- The FSM, shift register, bit counter and error logic live in the top.

## Test plan
- One 22-bit frame of 22'h2A5A5A with ready_i=1 → valid_o high for exactly one cycle, one cycle after frame_sync_i falls, with word_o=22'h2A5A5A; level_o returns to 0.
- Short frame of 21 bits → single frame_err_o pulse, valid_o stays 0, err_cnt_o=1 (macro on).
- Long frame of 23 bits → frame_err_o pulse, no word. A following 22-bit frame 22'h3FFFFF is accepted normally.
- ready_i=0, five frames 1..5 with FIFO_DEPTH=4:
  - level_o=4 and a single overflow_o pulse on frame 5.
  - Raising ready_i then yields 1,2,3,4 in that order.
- FIFO full and a commit coincident with a pop → no overflow_o, level_o stays 4, new word appears last.
- rst asserted at bit 10, released while frame_sync_i is still high → remainder ignored with no frame_err_o; the next full frame is received correctly.
